serial_to_multiple: RTL and testbench

SERIAL_TO_MULTIPLE -- requirements
Module: serial_to_multiple

---
 rtl/serialize_pkg.sv | 18 +
 rtl/stm_out_slice.sv | 42 ++++
 rtl/serial_to_multiple.sv | 142 ++++++++++++++
 tb/tb_serial_to_multiple.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serialize_pkg.sv
// Shared defaults, counter sizing and state type for the serial-to-wide packer.
package serialize_pkg;

    localparam int LANE_W_DEF    = 32;
    localparam int NUM_LANES_DEF = 4;
    localparam int CNT_W         = $clog2(NUM_LANES_DEF);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } stm_state_e;

    // Lane counter width for an arbitrary lane count (never narrower than 1 bit).
    function automatic int cnt_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/stm_out_slice.sv
// Output holding register with valid/ready: loads a finished word, drops valid on drain.
module stm_out_slice #(
    parameter int W = 128
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic         load_last_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         last_o,
    output logic         free_o
);

    logic         valid_q;
    logic [W-1:0] data_q;
    logic         last_q;

    // Load has priority; a drain without a new load empties the register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= load_data_i;
            last_q  <= load_last_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    // Room for a new word this edge: empty now, or being drained on this edge.
    assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/serial_to_multiple.sv
// Packs NUM_LANES serial beats (or fewer, closed by TLAST) into one wide output word.
module serial_to_multiple
    import serialize_pkg::*;
#(
    parameter int LANE_W    = LANE_W_DEF,
    parameter int NUM_LANES = NUM_LANES_DEF
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic [LANE_W-1:0]           input_r_TDATA,
    input  logic                        input_r_TVALID,
    output logic                        input_r_TREADY,
    input  logic                        input_r_TLAST,
    output logic [LANE_W*NUM_LANES-1:0] output_r_TDATA,
    output logic                        output_r_TVALID,
    input  logic                        output_r_TREADY,
    output logic                        output_r_TLAST,
    output logic                        err_short,
    output logic                        ap_idle
);

    localparam int WORD_W   = LANE_W * NUM_LANES;
    localparam int CNT_BITS = cnt_width(NUM_LANES);
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(NUM_LANES - 1);

    stm_state_e            state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0]     asm_q, asm_d;
    logic [WORD_W-1:0]     hold_data_q, hold_data_d;
    logic                  hold_last_q, hold_last_d;
    logic                  err_q, err_d;

    logic                  beat_acc;
    logic                  last_lane;
    logic                  complete;
    logic [WORD_W-1:0]     word_fill;

    logic                  slice_load;
    logic [WORD_W-1:0]     slice_load_data;
    logic                  slice_load_last;
    logic                  slice_free;
    logic                  slice_drain;

    assign input_r_TREADY = ap_rst_n && (state_q == FILL);
    assign beat_acc       = input_r_TVALID && input_r_TREADY;
    assign last_lane      = (cnt_q == LAST_CNT);
    assign complete       = beat_acc && (last_lane || input_r_TLAST);
    assign slice_drain    = output_r_TVALID && output_r_TREADY;

    // Assembly word with the current beat dropped into lane cnt.
    always_comb begin
        word_fill = asm_q;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (cnt_q == CNT_BITS'(k)) begin
                word_fill[k*LANE_W +: LANE_W] = input_r_TDATA;
            end
        end
    end

    // Next-state: lane counting, word completion, hand-off to output or hold.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        asm_d           = asm_q;
        hold_data_d     = hold_data_q;
        hold_last_d     = hold_last_q;
        err_d           = err_q;
        slice_load      = 1'b0;
        slice_load_data = '0;
        slice_load_last = 1'b0;
        case (state_q)
            FILL: begin
                if (complete) begin
                    cnt_d = '0;
                    asm_d = '0;
                    if (input_r_TLAST && !last_lane) begin
                        err_d = 1'b1;
                    end
                    if (slice_free) begin
                        slice_load      = 1'b1;
                        slice_load_data = word_fill;
                        slice_load_last = input_r_TLAST;
                    end else begin
                        hold_data_d = word_fill;
                        hold_last_d = input_r_TLAST;
                        state_d     = HOLD;
                    end
                end else if (beat_acc) begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                    asm_d = word_fill;
                end
            end
            HOLD: begin
                if (slice_drain) begin
                    slice_load      = 1'b1;
                    slice_load_data = hold_data_q;
                    slice_load_last = hold_last_q;
                    state_d         = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State registers; reset discards any partial or held word.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            asm_q       <= '0;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            err_q       <= err_d;
        end
    end

    stm_out_slice #(
        .W (WORD_W)
    ) u_out_slice (
        .clk_i       (ap_clk),
        .rst_ni      (ap_rst_n),
        .load_i      (slice_load),
        .load_data_i (slice_load_data),
        .load_last_i (slice_load_last),
        .ready_i     (output_r_TREADY),
        .valid_o     (output_r_TVALID),
        .data_o      (output_r_TDATA),
        .last_o      (output_r_TLAST),
        .free_o      (slice_free)
    );

    assign err_short = err_q;
    assign ap_idle   = (cnt_q == '0) && (state_q == FILL) && !output_r_TVALID;

endmodule

// File: tb/tb_serial_to_multiple.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_serial_to_multiple;

    localparam int LW = 32;
    localparam int NL = 4;
    localparam int WW = LW * NL;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [LW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [WW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          err;
    logic          idle;

    typedef struct {
        logic [WW-1:0] data;
        logic          last;
    } word_t;

    word_t         expq[$];
    logic [LW-1:0] part[$];
    bit            err_m;
    int            tests = 0;
    int            fails = 0;

    serial_to_multiple #(
        .LANE_W    (LW),
        .NUM_LANES (NL)
    ) dut (
        .ap_clk          (clk),
        .ap_rst_n        (rst_n),
        .input_r_TDATA   (in_data),
        .input_r_TVALID  (in_valid),
        .input_r_TREADY  (in_ready),
        .input_r_TLAST   (in_last),
        .output_r_TDATA  (out_data),
        .output_r_TVALID (out_valid),
        .output_r_TREADY (out_ready),
        .output_r_TLAST  (out_last),
        .err_short       (err),
        .ap_idle         (idle)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: collect beats; a word closes at NL beats or on TLAST, lanes beyond the last beat are zero.
    task automatic model_beat(input logic [LW-1:0] d, input logic l);
        word_t w;
        part.push_back(d);
        if (part.size() == NL || l) begin
            w.data = '0;
            for (int i = 0; i < part.size(); i++) w.data[i*LW +: LW] = part[i];
            w.last = l;
            if (l && part.size() < NL) err_m = 1'b1;
            expq.push_back(w);
            part.delete();
        end
    endtask

    task automatic model_reset();
        part.delete();
        expq.delete();
        err_m = 1'b0;
    endtask

    // Words pending = output register + held word; input stalls only when both are occupied.
    task automatic check_state();
        chk("in_ready", in_ready, expq.size() < 2);
        chk("out_valid", out_valid, expq.size() > 0);
        if (expq.size() > 0) begin
            chk("out_data", out_data, expq[0].data);
            chk("out_last", out_last, expq[0].last);
        end
        chk("ap_idle", idle, (part.size() == 0) && (expq.size() == 0));
        chk("err_short", err, err_m);
    endtask

    task automatic tick();
        bit            ihs, ohs;
        logic [LW-1:0] d;
        logic          l;
        ihs = in_valid && in_ready;
        ohs = out_valid && out_ready;
        d   = in_data;
        l   = in_last;
        @(posedge clk);
        #1;
        if (ohs) begin
            tests++;
            assert (expq.size() > 0) else begin
                fails++;
                $error("FAIL drain_unexpected observed=drain expected=no_word");
            end
            if (expq.size() > 0) void'(expq.pop_front());
        end
        if (ihs) model_beat(d, l);
        check_state();
    endtask

    task automatic send(input logic [LW-1:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        tick();
    endtask

    task automatic quiet(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        logic [WW-1:0] c;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_reset();

        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_idle", idle, 1);

        // Four back-to-back beats form one full word one cycle after the last beat.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(LW'((i + 1) * 'h11), 1'b0);
        c = 128'h00000044_00000033_00000022_00000011;
        chk("full_word_data", out_data, c);
        chk("full_word_last", out_last, 0);
        chk("full_word_valid", out_valid, 1);
        quiet(1);

        // TLAST on the final lane closes a full word without flagging an error.
        for (int i = 0; i < 4; i++) send(LW'(32'h200 + i), i == 3);
        chk("tlast_full_last", out_last, 1);
        chk("tlast_full_err", err, 0);
        quiet(1);

        // Twelve streaming beats: input never stalls.
        for (int i = 0; i < 12; i++) begin
            send(LW'(32'h300 + i), 1'b0);
            chk("stream_ready", in_ready, 1);
        end
        quiet(2);

        // Downstream stalled: first word parks in output, second is held, input stalls.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(LW'(32'h100 + i), 1'b0);
        in_valid = 1'b0;
        chk("hold_in_ready", in_ready, 0);
        chk("hold_lane0", out_data[LW-1:0], 32'h100);
        out_ready = 1'b1;
        tick();
        chk("release_in_ready", in_ready, 1);
        chk("release_lane0", out_data[LW-1:0], 32'h104);
        quiet(2);

        // Short word: two beats then TLAST, upper lanes zero, sticky error.
        send(32'hA, 1'b0);
        send(32'hB, 1'b1);
        c = 128'h00000000_00000000_0000000B_0000000A;
        chk("short_data", out_data, c);
        chk("short_last", out_last, 1);
        chk("short_err", err, 1);
        quiet(3);
        chk("short_err_sticky", err, 1);

        // Reset mid-word drops the partial word immediately.
        out_ready = 1'b0;
        send(32'h55, 1'b0);
        send(32'h66, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_last", out_last, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_err", err, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("mid_rst_idle", idle, 1);
        chk("mid_rst_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(LW'(i + 1), 1'b0);
        c = 128'h00000004_00000003_00000002_00000001;
        chk("clean_word_data", out_data, c);
        chk("clean_word_last", out_last, 0);
        quiet(1);

        // Random traffic with random backpressure and occasional TLAST.
        repeat (400) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Close any partial word and drain, bounded.
        out_ready = 1'b1;
        in_data   = 32'hFEED;
        in_last   = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8 && in_valid; i++) begin
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                in_last  = 1'b0;
            end else begin
                tick();
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < 8 && expq.size() > 0; i++) tick();
        chk("final_idle", idle, 1);
        chk("final_out_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
